// File: rtl/rom_lookup_pkg.sv
// Shared constants for the pipelined lookup ROM: the 16-byte base table, the content rule
// and the legal parameter ranges.
package rom_lookup_pkg;

    localparam int ADDR_W_MIN   = 4;
    localparam int ADDR_W_MAX   = 10;
    localparam int DATA_W_MIN   = 8;
    localparam int DATA_W_MAX   = 64;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    // Byte i of the table lives at bits [8*i +: 8].
    localparam logic [127:0] ROM_T = {
        8'h51, 8'h99, 8'hA9, 8'h8C, 8'h81, 8'h36, 8'h49, 8'h61,
        8'hFF, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12
    };

    function automatic bit rom_params_ok(input int addr_w, input int data_w, input int read_lat);
        return (addr_w >= ADDR_W_MIN) && (addr_w <= ADDR_W_MAX) &&
               (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) && (data_w % 8 == 0) &&
               (read_lat >= READ_LAT_MIN) && (read_lat <= READ_LAT_MAX);
    endfunction

    // Entry i: base byte T[i[3:0]] ^ i[addr_w-1:4], replicated across data_w/8 byte lanes.
    function automatic logic [DATA_W_MAX-1:0] rom_word(input logic [ADDR_W_MAX-1:0] addr,
                                                       input int addr_w, input int data_w);
        logic [ADDR_W_MAX-1:0] masked;
        logic [7:0]            base;
        logic [DATA_W_MAX-1:0] word;
        for (int b = 0; b < ADDR_W_MAX; b++) begin
            masked[b] = (b < addr_w) ? addr[b] : 1'b0;
        end
        base = ROM_T[{masked[3:0], 3'b000} +: 8] ^ {2'b00, masked[ADDR_W_MAX-1:4]};
        word = '0;
        for (int k = 0; k < DATA_W_MAX / 8; k++) begin
            if (k < data_w / 8) begin
                word[k*8 +: 8] = base;
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/rom_pipe_stage.sv
// One pipeline register of the lookup ROM: valid + data (+ parity under ROM_LOOKUP_PARITY_EN).
// Latency: 1 cycle when adv is high.
// Backpressure: holds its contents while adv is low; data is zeroed whenever it loads an invalid slot.
module rom_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_data,
`ifdef ROM_LOOKUP_PARITY_EN
    input  logic              d_parity,
    output logic              q_parity,
`endif
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid  <= 1'b0;
            q_data   <= '0;
`ifdef ROM_LOOKUP_PARITY_EN
            q_parity <= 1'b0;
`endif
        end else if (adv) begin
            q_valid  <= d_valid;
            q_data   <= d_valid ? d_data : '0;
`ifdef ROM_LOOKUP_PARITY_EN
            q_parity <= d_valid ? d_parity : 1'b0;
`endif
        end
    end

endmodule

// File: rtl/rom_lookup_pipe.sv
// Pipelined constant-table lookup ROM, valid/ready on both sides; ROM_LOOKUP_PARITY_EN adds rsp_parity.
// Latency: READ_LAT cycles from request accept to rsp_valid; one request per cycle, bubbles kept.
// Backpressure: rsp_valid && !rsp_ready freezes every stage and drops req_ready.
module rom_lookup_pipe #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_en,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
`ifdef ROM_LOOKUP_PARITY_EN
    output logic              rsp_parity,
`endif
    output logic [15:0]       rsp_count
);
    import rom_lookup_pkg::*;

    if (!rom_params_ok(ADDR_W, DATA_W, READ_LAT)) begin : g_bad_params
        $error("rom_lookup_pipe: illegal ADDR_W/DATA_W/READ_LAT combination");
    end

    logic              adv;
    logic              stg_vld [READ_LAT+1];
    logic [DATA_W-1:0] stg_dat [READ_LAT+1];

    // Whole pipe moves together; a stalled head blocks intake as well.
    assign adv       = !rsp_valid || rsp_ready;
    assign req_ready = adv;

    // Index 0 is the combinational lookup feeding the first register.
    assign stg_vld[0] = req_valid;
    assign stg_dat[0] = req_en ? DATA_W'(rom_word(ADDR_W_MAX'(req_addr), ADDR_W, DATA_W)) : '0;

`ifdef ROM_LOOKUP_PARITY_EN
    logic stg_par [READ_LAT+1];
    assign stg_par[0] = ^stg_dat[0];
`endif

    for (genvar s = 0; s < READ_LAT; s++) begin : g_stage
        rom_pipe_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .d_valid  (stg_vld[s]),
            .d_data   (stg_dat[s]),
`ifdef ROM_LOOKUP_PARITY_EN
            .d_parity (stg_par[s]),
            .q_parity (stg_par[s+1]),
`endif
            .q_valid  (stg_vld[s+1]),
            .q_data   (stg_dat[s+1])
        );
    end

    // Stages zero their data on invalid loads, so rsp_data is already 0 when idle.
    assign rsp_valid = stg_vld[READ_LAT];
    assign rsp_data  = stg_dat[READ_LAT];
`ifdef ROM_LOOKUP_PARITY_EN
    assign rsp_parity = stg_par[READ_LAT];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_count <= '0;
        end else if (rsp_valid && rsp_ready && (rsp_count != 16'hFFFF)) begin
            rsp_count <= rsp_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_rom_lookup_pipe.sv
// Scoreboard bench for rom_lookup_pipe: three configurations (defaults, 5/16/lat4, 10/64/lat1),
// directed vectors with hand values plus randomized valid/ready traffic.
module tb_rom_lookup_pipe;

    localparam int AWS  [3] = '{4, 5, 10};
    localparam int DWS  [3] = '{8, 16, 64};
    localparam int LATS [3] = '{2, 4, 1};
    localparam logic [7:0] TB_T [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hFF,
                                         8'h61, 8'h49, 8'h36, 8'h81, 8'h8C, 8'hA9, 8'h99, 8'h51};

    typedef struct {
        logic [63:0] data;
        int          acc;
        bit          lat_chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic        req_vld [3];
    logic        req_en  [3];
    logic [9:0]  req_addr[3];
    logic        rsp_rdy [3];
    logic        req_rdy [3];
    logic        rsp_vld [3];
    logic [63:0] rsp_dat [3];
    logic [15:0] rsp_cnt [3];
    logic [7:0]  a_dat;
    logic [15:0] b_dat;
    logic [63:0] c_dat;
    exp_t        exp_q   [3][$];
    int          stall_cnt[3];
    bit          done    [3];
`ifdef ROM_LOOKUP_PARITY_EN
    logic        rsp_par [3];
`endif

    assign rsp_dat[0] = 64'(a_dat);
    assign rsp_dat[1] = 64'(b_dat);
    assign rsp_dat[2] = c_dat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_lookup_pipe u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_vld[0]), .req_ready(req_rdy[0]), .req_addr(req_addr[0][3:0]), .req_en(req_en[0]),
        .rsp_valid(rsp_vld[0]), .rsp_ready(rsp_rdy[0]), .rsp_data(a_dat),
`ifdef ROM_LOOKUP_PARITY_EN
        .rsp_parity(rsp_par[0]),
`endif
        .rsp_count(rsp_cnt[0])
    );

    rom_lookup_pipe #(.ADDR_W(5), .DATA_W(16), .READ_LAT(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_vld[1]), .req_ready(req_rdy[1]), .req_addr(req_addr[1][4:0]), .req_en(req_en[1]),
        .rsp_valid(rsp_vld[1]), .rsp_ready(rsp_rdy[1]), .rsp_data(b_dat),
`ifdef ROM_LOOKUP_PARITY_EN
        .rsp_parity(rsp_par[1]),
`endif
        .rsp_count(rsp_cnt[1])
    );

    rom_lookup_pipe #(.ADDR_W(10), .DATA_W(64), .READ_LAT(1)) u_dut_c (
        .clk(clk), .rst(rst),
        .req_valid(req_vld[2]), .req_ready(req_rdy[2]), .req_addr(req_addr[2]), .req_en(req_en[2]),
        .rsp_valid(rsp_vld[2]), .rsp_ready(rsp_rdy[2]), .rsp_data(c_dat),
`ifdef ROM_LOOKUP_PARITY_EN
        .rsp_parity(rsp_par[2]),
`endif
        .rsp_count(rsp_cnt[2])
    );

    task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @cyc %0d: got %h required %h", name, d, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input int addr, input int dw);
        logic [7:0]  b;
        logic [63:0] w;
        b = TB_T[addr % 16] ^ 8'(addr >> 4);
        w = '0;
        for (int k = 0; k < dw / 8; k++) w[k*8 +: 8] = b;
        return w;
    endfunction

    // Drive one request (called just after a rising edge); push the expectation when it is accepted.
    task automatic send(input int d, input int addr, input bit en, input logic [63:0] exp, input bit lc);
        int waits;
        waits = 0;
        req_vld[d]  = 1'b1;
        req_addr[d] = 10'(addr);
        req_en[d]   = en;
        forever begin
            @(negedge clk);
            if (req_rdy[d]) begin
                exp_q[d].push_back('{data: exp, acc: cyc, lat_chk: lc});
                break;
            end
            waits++;
            if (waits > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout dut%0d: req_ready stayed 0 for %0d cycles, required 1", d, waits);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_vld[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (exp_q[d].size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(d, "drain_pending", 64'(exp_q[d].size()), 64'd0);
    endtask

    task automatic rand_run(input int d, input int n);
        int a;
        bit en;
        for (int i = 0; i < n; i++) begin
            a  = int'($urandom_range(0, (1 << AWS[d]) - 1));
            en = ($urandom_range(0, 4) != 0);
            while ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(d, a, en, en ? ref_word(a, DWS[d]) : 64'd0, 1'b0);
        end
        done[d] = 1'b1;
    endtask

    task automatic rdy_rand(input int d);
        while (!done[d]) begin
            @(posedge clk); #1;
            rsp_rdy[d] = ($urandom_range(0, 2) != 0);
        end
        rsp_rdy[d] = 1'b1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        int          mcnt = 0;
        bit          prev_stall = 1'b0;
        logic [63:0] prev_dat = '0;
        exp_t        e;
        always @(negedge clk) begin
            if (rst) begin
                exp_q[g].delete();
                mcnt       = 0;
                prev_stall = 1'b0;
            end else if (!rsp_vld[g]) begin
                chk(g, "idle_data_zero", rsp_dat[g], 64'd0);
                prev_stall = 1'b0;
            end else if (!rsp_rdy[g]) begin
                chk(g, "stall_req_ready", 64'(req_rdy[g]), 64'd0);
                if (prev_stall) chk(g, "stall_data_hold", rsp_dat[g], prev_dat);
                prev_stall = 1'b1;
                prev_dat   = rsp_dat[g];
                stall_cnt[g]++;
            end else begin
                prev_stall = 1'b0;
                if (exp_q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp dut%0d @cyc %0d: got data %h, required no response",
                             g, cyc, rsp_dat[g]);
                end else begin
                    e = exp_q[g].pop_front();
                    chk(g, "rsp_data", rsp_dat[g], e.data);
`ifdef ROM_LOOKUP_PARITY_EN
                    chk(g, "rsp_parity", 64'(rsp_par[g]), 64'(^e.data));
`endif
                    if (e.lat_chk) chk(g, "latency", 64'(cyc - e.acc), 64'(LATS[g]));
                end
                chk(g, "rsp_count", 64'(rsp_cnt[g]), 64'(mcnt));
                mcnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_vld[d] = 1'b0; req_en[d] = 1'b0; req_addr[d] = '0; rsp_rdy[d] = 1'b1;
            stall_cnt[d] = 0; done[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk(0, "reset_rsp_valid", 64'(rsp_vld[0]), 64'd0);
        chk(0, "reset_rsp_data",  rsp_dat[0], 64'd0);
        chk(0, "reset_rsp_count", 64'(rsp_cnt[0]), 64'd0);
        chk(0, "reset_req_ready", 64'(req_rdy[0]), 64'd1);

        // Defaults: hand-computed words, latency checked against accept cycle.
        send(0, 'h3, 1'b1, 64'h78, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        send(0, 'hF, 1'b1, 64'h51, 1'b1);
        send(0, 'h5, 1'b0, 64'h00, 1'b1);
        send(0, 'h0, 1'b1, 64'h12, 1'b1);
        send(0, 'h1, 1'b1, 64'h34, 1'b1);
        drain(0);
        chk(0, "count_after_directed", 64'(rsp_cnt[0]), 64'd5);

        // Back-to-back 0..7 with a 3-cycle consumer stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) send(0, i, 1'b1, 64'(TB_T[i]), 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 rsp_rdy[0] = 1'b0;
                repeat (3) @(posedge clk);
                #1 rsp_rdy[0] = 1'b1;
            end
        join
        drain(0);
        chk(0, "stall_cycles", 64'(stall_cnt[0]), 64'd3);
        chk(0, "count_after_stream", 64'(rsp_cnt[0]), 64'd13);

        // Reset with two requests in flight, consumer held off.
        rsp_rdy[0] = 1'b0;
        send(0, 'h0, 1'b1, 64'h12, 1'b0);
        send(0, 'h1, 1'b1, 64'h34, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk(0, "midrst_rsp_valid", 64'(rsp_vld[0]), 64'd0);
        chk(0, "midrst_rsp_data",  rsp_dat[0], 64'd0);
        chk(0, "midrst_rsp_count", 64'(rsp_cnt[0]), 64'd0);
        chk(0, "midrst_req_ready", 64'(req_rdy[0]), 64'd1);
        rsp_rdy[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk(0, "no_stale_count", 64'(rsp_cnt[0]), 64'd0);

        // Wide configuration, hand values.
        send(1, 'h1F, 1'b1, 64'h5050, 1'b1);
        send(1, 'h02, 1'b1, 64'h5656, 1'b1);
        send(1, 'h13, 1'b0, 64'h0000, 1'b1);
        drain(1);

        // READ_LAT 4 and 1 under random valid/ready against the reference model.
        fork
            rand_run(1, 1000);
            rand_run(2, 1000);
            rdy_rand(1);
            rdy_rand(2);
        join
        drain(1);
        drain(2);
        chk(1, "count_after_random", 64'(rsp_cnt[1]), 64'd1003);
        chk(2, "count_after_random", 64'(rsp_cnt[2]), 64'd1000);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
